// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding and command byte constants.
//   Exports: ps2_state_e (transmitter states), CMD_SET_LED, CMD_ECHO, CMD_RESET, RSP_ACK.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PAR,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: synchronises the PS/2 clock/data pad inputs and flags device falling clock edges.
//   clk, rst     : system clock, asynchronous active-high reset
//   ps2_clk_i    : raw PS/2 clock line (asynchronous)
//   ps2_data_i   : raw PS/2 data line (asynchronous)
//   clk_s_o      : synchronised PS/2 clock
//   data_s_o     : synchronised PS/2 data
//   fall_o       : one-cycle pulse per falling edge of the PS/2 clock
module ps2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic fall_o
);

    logic [2:0] clk_q;
    logic [1:0] data_q;

    // Reset to the idle-high line level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_q  <= '1;
            data_q <= '1;
        end else begin
            clk_q  <= {clk_q[1:0], ps2_clk_i};
            data_q <= {data_q[0], ps2_data_i};
        end
    end

    assign clk_s_o  = clk_q[1];
    assign data_s_o = data_q[1];
    assign fall_o   = clk_q[2] & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (inhibit, request-to-send, 8N-odd-1 shift-out, ACK check).
//   clk, rst        : system clock, asynchronous active-high reset
//   tx_data/valid   : command byte and its request; accepted when tx_valid && tx_ready
//   tx_ready        : high in IDLE
//   ps2_clk/data    : pad read-back of the open-drain lines
//   ps2_clk_oe/data_oe : 1 pulls the corresponding line low
//   busy            : high outside IDLE
//   done / err      : end-of-transaction pulse; err marks NACK or timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // One counter times both the inhibit window and the inter-edge timeout.
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_DRV  = CW'(INHIBIT_CYCLES - 3);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYCLES);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          par_q, par_d;
    logic          data_oe_q, data_oe_d;
    logic          nack_q, nack_d;
    logic          clk_s, data_s, fall;
    logic          watched;

    ps2_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .fall_o     (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            par_q     <= 1'b0;
            data_oe_q <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            par_q     <= par_d;
            data_oe_q <= data_oe_d;
            nack_q    <= nack_d;
        end
    end

    assign watched = (state_q != IDLE) && (state_q != INHIBIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
        shift_d   = shift_q;
        idx_d     = idx_q;
        par_d     = par_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                cnt_d     = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = ~^tx_data;
                    nack_d  = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                // Registered drive: asserting at count N-3 makes data low in the last two cycles.
                data_oe_d = cnt_q >= INH_DRV;
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end
            RTS: if (fall) begin
                // The first device edge after RTS already shifts D0 onto the line.
                data_oe_d = ~shift_q[0];
                idx_d     = 3'd1;
                state_d   = DATA;
            end
            DATA: if (fall) begin
                data_oe_d = ~shift_q[idx_q];
                idx_d     = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = PAR;
            end
            PAR: if (fall) begin
                data_oe_d = ~par_q;
                state_d   = STOP;
            end
            STOP: if (fall) begin
                data_oe_d = 1'b0;
                state_d   = ACK;
            end
            ACK: if (fall) begin
                nack_d  = data_s;
                state_d = WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                done    = 1'b1;
                err     = nack_q;
                state_d = IDLE;
            end
        endcase
        if (watched && fall) cnt_d = '0;
        // A fall in the same cycle wins over an expiring timeout.
        if (watched && !fall && cnt_q == TMO) begin
            state_d   = IDLE;
            data_oe_d = 1'b0;
            done      = 1'b1;
            err       = 1'b1;
        end
    end

    assign tx_ready    = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign ps2_clk_oe  = state_q == INHIBIT;
    assign ps2_data_oe = data_oe_q;

endmodule
